// File: rtl/bsg_locking_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsg_locking_arb_pkg
// Description : Shared types and width helpers for the locking round-robin
//               arbiter. Holds the lock-state enumeration and "safe" clog2
//               helpers that never return a zero width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bsg_locking_arb_pkg;

  // Lock state of the arbiter.
  typedef enum logic [0:0] {
    e_unlocked = 1'b0,
    e_locked   = 1'b1
  } lock_state_e;

  // clog2 that never returns less than one bit, so a vector declared with it
  // is always legal even for degenerate parameter values.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must be able to hold the value max_val.
  function automatic int cnt_width(input int max_val);
    return safe_clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_arb_rr_sel.sv
`default_nettype none
// ============================================================================
// Module      : bsg_arb_rr_sel
// Description : Combinational requester selector. With rr_p=1 the first set
//               request after last_i (wrapping) wins; with rr_p=0 the lowest
//               set index wins and last_i has no influence.
// Ports       : reqs_i  - request vector
//               last_i  - index granted most recently (round-robin pointer)
//               grant_o - one-hot (or zero) selection
//               idx_o   - binary index of the selection
//               v_o     - a selection was made
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_arb_rr_sel
  import bsg_locking_arb_pkg::*;
#(
  parameter  int width_p = 16,
  parameter  int rr_p    = 1,
  localparam int c_idx_w = safe_clog2(width_p)
) (
  input  logic [width_p-1:0] reqs_i,
  input  logic [c_idx_w-1:0] last_i,
  output logic [width_p-1:0] grant_o,
  output logic [c_idx_w-1:0] idx_o,
  output logic               v_o
);

  localparam logic [width_p-1:0] c_one = width_p'(1);

  logic               w_lo_v;
  logic               w_hi_v;
  logic [c_idx_w-1:0] w_lo_idx;
  logic [c_idx_w-1:0] w_hi_idx;

  // Two priority searches: the lowest requester overall, and the lowest
  // requester strictly above last_i. Scanning downward lets the last hit
  // be the lowest index.
  always_comb begin
    w_lo_v   = 1'b0;
    w_lo_idx = '0;
    w_hi_v   = 1'b0;
    w_hi_idx = '0;
    for (int i = width_p - 1; i >= 0; i--) begin
      if (reqs_i[i]) begin
        w_lo_v   = 1'b1;
        w_lo_idx = c_idx_w'(i);
        if (i > int'(last_i)) begin
          w_hi_v   = 1'b1;
          w_hi_idx = c_idx_w'(i);
        end
      end
    end
  end

  // Round-robin: prefer the requester above the pointer; if none exists the
  // search wraps to the lowest requester overall.
  always_comb begin
    v_o = w_lo_v;
    if ((rr_p != 0) && w_hi_v) begin
      idx_o = w_hi_idx;
    end else begin
      idx_o = w_lo_idx;
    end
    grant_o = w_lo_v ? (c_one << idx_o) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/bsg_locking_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : bsg_locking_arb_rr
// Description : Locking arbiter. Arbitrates among inputs_p requesters with
//               fixed or round-robin priority, then locks onto the winner so
//               a multi-beat transfer is not interleaved. The lock releases
//               on unlock_i, after max_grants_p grants, or after
//               idle_timeout_p consecutive cycles without a holder request.
// Ports       : clk_i     - clock
//               reset_i   - asynchronous active-high reset
//               ready_i   - downstream ready, gates every grant
//               unlock_i  - synchronous lock release
//               reqs_i    - request vector
//               grants_o  - one-hot-or-zero grant (combinational)
//               locked_o  - lock currently held
//               lock_id_o - index of the lock holder (valid when locked_o)
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_locking_arb_rr
  import bsg_locking_arb_pkg::*;
#(
  parameter  int inputs_p       = 16,
  parameter  int rr_p           = 1,
  parameter  int max_grants_p   = 0,
  parameter  int idle_timeout_p = 0,
  localparam int c_id_w         = safe_clog2(inputs_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                ready_i,
  input  logic                unlock_i,
  input  logic [inputs_p-1:0] reqs_i,
  output logic [inputs_p-1:0] grants_o,
  output logic                locked_o,
  output logic [c_id_w-1:0]   lock_id_o
);

  localparam int c_gcnt_w = cnt_width(max_grants_p);
  localparam int c_icnt_w = cnt_width(idle_timeout_p);

  localparam logic [c_gcnt_w-1:0] c_gcnt_max = c_gcnt_w'(max_grants_p);
  localparam logic [c_icnt_w-1:0] c_icnt_max = c_icnt_w'(idle_timeout_p);
  localparam logic [inputs_p-1:0] c_one      = inputs_p'(1);
  localparam logic [c_id_w-1:0]   c_last_rst = c_id_w'(inputs_p - 1);

  lock_state_e         r_state;
  lock_state_e         w_state_nxt;
  logic [c_id_w-1:0]   r_lock_id;
  logic [c_id_w-1:0]   w_lock_id_nxt;
  logic [c_id_w-1:0]   r_last;
  logic [c_id_w-1:0]   w_last_nxt;
  logic [c_gcnt_w-1:0] r_gcnt;
  logic [c_gcnt_w-1:0] w_gcnt_nxt;
  logic [c_gcnt_w-1:0] w_gcnt_inc;
  logic [c_icnt_w-1:0] r_icnt;
  logic [c_icnt_w-1:0] w_icnt_nxt;
  logic [c_icnt_w-1:0] w_icnt_inc;

  logic [inputs_p-1:0] w_sel_grant;
  logic [c_id_w-1:0]   w_sel_idx;
  logic                w_sel_v;
  logic                w_locked;
  logic                w_holder_req;
  logic                w_grant_v;
  logic [c_id_w-1:0]   w_grant_idx;
  logic                w_release;

  bsg_arb_rr_sel #(
    .width_p (inputs_p),
    .rr_p    (rr_p)
  ) u_sel (
    .reqs_i  (reqs_i),
    .last_i  (r_last),
    .grant_o (w_sel_grant),
    .idx_o   (w_sel_idx),
    .v_o     (w_sel_v)
  );

  assign w_locked     = (r_state == e_locked);
  assign w_holder_req = reqs_i[r_lock_id];

  // While locked only the holder can win; everyone else is masked off.
  always_comb begin
    grants_o = '0;
    if (ready_i) begin
      if (w_locked) begin
        grants_o = w_holder_req ? (c_one << r_lock_id) : '0;
      end else begin
        grants_o = w_sel_grant;
      end
    end
  end

  assign w_grant_v   = ready_i & (w_locked ? w_holder_req : w_sel_v);
  assign w_grant_idx = w_locked ? r_lock_id : w_sel_idx;

  // Saturating increments: the counters never wrap back to zero.
  assign w_gcnt_inc = (r_gcnt == c_gcnt_max) ? r_gcnt : r_gcnt + c_gcnt_w'(1);
  assign w_icnt_inc = (r_icnt == c_icnt_max) ? r_icnt : r_icnt + c_icnt_w'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= e_unlocked;
      r_lock_id <= '0;
      r_last    <= c_last_rst;
      r_gcnt    <= '0;
      r_icnt    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_last    <= w_last_nxt;
      r_gcnt    <= w_gcnt_nxt;
      r_icnt    <= w_icnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    w_gcnt_nxt    = r_gcnt;
    w_icnt_nxt    = r_icnt;
    w_release     = 1'b0;
    // The round-robin pointer follows every grant, locked or not.
    w_last_nxt    = w_grant_v ? w_grant_idx : r_last;

    case (r_state)
      e_unlocked: begin
        // A single-grant limit means every lock would release immediately,
        // so the block behaves as a plain arbiter and never locks.
        if (w_grant_v && !unlock_i && (max_grants_p != 1)) begin
          w_state_nxt   = e_locked;
          w_lock_id_nxt = w_sel_idx;
          w_gcnt_nxt    = (max_grants_p != 0) ? c_gcnt_w'(1) : '0;
          w_icnt_nxt    = '0;
        end
      end

      e_locked: begin
        if (w_grant_v && (max_grants_p != 0)) begin
          w_gcnt_nxt = w_gcnt_inc;
          if (w_gcnt_inc == c_gcnt_max) begin
            w_release = 1'b1;
          end
        end

        // Idle is judged on the request alone; a stalled-but-requesting
        // holder keeps its lock.
        if (!w_holder_req) begin
          if (idle_timeout_p != 0) begin
            w_icnt_nxt = w_icnt_inc;
            if (w_icnt_inc == c_icnt_max) begin
              w_release = 1'b1;
            end
          end
        end else begin
          w_icnt_nxt = '0;
        end

        if (unlock_i) begin
          w_release = 1'b1;
        end

        if (w_release) begin
          w_state_nxt = e_unlocked;
          w_gcnt_nxt  = '0;
          w_icnt_nxt  = '0;
        end
      end

      default: begin
        w_state_nxt = e_unlocked;
        w_gcnt_nxt  = '0;
        w_icnt_nxt  = '0;
      end
    endcase
  end

  assign locked_o  = w_locked;
  assign lock_id_o = r_lock_id;

endmodule
`default_nettype wire

// File: tb/tb_bsg_locking_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_locking_arb_rr
// Description : Self-checking bench for bsg_locking_arb_rr. Five instances
//               with different parameter sets share a clock and reset; each
//               has its own stimulus and a reference model of the lock rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_locking_arb_rr;

  localparam int N  = 16;
  localparam int NI = 5;

  // Per-instance configuration: fixed, rr, rr+max3, rr+idle4, rr+max1.
  localparam int CFG_RR [NI] = '{0, 1, 1, 1, 1};
  localparam int CFG_MG [NI] = '{0, 0, 3, 0, 1};
  localparam int CFG_IT [NI] = '{0, 0, 0, 4, 0};

  logic clk = 1'b0;
  logic rst;

  logic [NI-1:0][N-1:0] t_reqs;
  logic [NI-1:0]        t_ready;
  logic [NI-1:0]        t_unlock;
  logic [NI-1:0][N-1:0] t_grants;
  logic [NI-1:0]        t_locked;
  logic [NI-1:0][3:0]   t_id;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state.
  int m_locked [NI];
  int m_id     [NI];
  int m_last   [NI];
  int m_gc     [NI];
  int m_ic     [NI];

  always #5 clk = ~clk;

  bsg_locking_arb_rr #(.inputs_p(N), .rr_p(0), .max_grants_p(0), .idle_timeout_p(0)) u_fix (
    .clk_i(clk), .reset_i(rst), .ready_i(t_ready[0]), .unlock_i(t_unlock[0]),
    .reqs_i(t_reqs[0]), .grants_o(t_grants[0]), .locked_o(t_locked[0]), .lock_id_o(t_id[0]));

  bsg_locking_arb_rr #(.inputs_p(N), .rr_p(1), .max_grants_p(0), .idle_timeout_p(0)) u_rr (
    .clk_i(clk), .reset_i(rst), .ready_i(t_ready[1]), .unlock_i(t_unlock[1]),
    .reqs_i(t_reqs[1]), .grants_o(t_grants[1]), .locked_o(t_locked[1]), .lock_id_o(t_id[1]));

  bsg_locking_arb_rr #(.inputs_p(N), .rr_p(1), .max_grants_p(3), .idle_timeout_p(0)) u_mg (
    .clk_i(clk), .reset_i(rst), .ready_i(t_ready[2]), .unlock_i(t_unlock[2]),
    .reqs_i(t_reqs[2]), .grants_o(t_grants[2]), .locked_o(t_locked[2]), .lock_id_o(t_id[2]));

  bsg_locking_arb_rr #(.inputs_p(N), .rr_p(1), .max_grants_p(0), .idle_timeout_p(4)) u_it (
    .clk_i(clk), .reset_i(rst), .ready_i(t_ready[3]), .unlock_i(t_unlock[3]),
    .reqs_i(t_reqs[3]), .grants_o(t_grants[3]), .locked_o(t_locked[3]), .lock_id_o(t_id[3]));

  bsg_locking_arb_rr #(.inputs_p(N), .rr_p(1), .max_grants_p(1), .idle_timeout_p(0)) u_pl (
    .clk_i(clk), .reset_i(rst), .ready_i(t_ready[4]), .unlock_i(t_unlock[4]),
    .reqs_i(t_reqs[4]), .grants_o(t_grants[4]), .locked_o(t_locked[4]), .lock_id_o(t_id[4]));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  // Index the rules say should be granted now, or -1 for none.
  function automatic int model_grant(input int k);
    int j;
    if (!t_ready[k]) return -1;
    if (m_locked[k] != 0) return t_reqs[k][m_id[k]] ? m_id[k] : -1;
    for (int off = 1; off <= N; off++) begin
      j = (CFG_RR[k] != 0) ? (m_last[k] + off) % N : off - 1;
      if (t_reqs[k][j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model_seq
    int g;
    int ngc;
    int nic;
    bit rel;
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        m_locked[k] <= 0;
        m_id[k]     <= 0;
        m_last[k]   <= N - 1;
        m_gc[k]     <= 0;
        m_ic[k]     <= 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        g   = model_grant(k);
        ngc = m_gc[k];
        nic = m_ic[k];
        rel = 1'b0;
        if (g >= 0) m_last[k] <= g;
        if (m_locked[k] == 0) begin
          if (g >= 0 && !t_unlock[k] && CFG_MG[k] != 1) begin
            m_locked[k] <= 1;
            m_id[k]     <= g;
            m_gc[k]     <= (CFG_MG[k] != 0) ? 1 : 0;
            m_ic[k]     <= 0;
          end
        end else begin
          if (g >= 0 && CFG_MG[k] != 0) begin
            ngc = ngc + 1;
            if (ngc == CFG_MG[k]) rel = 1'b1;
          end
          if (!t_reqs[k][m_id[k]]) begin
            if (CFG_IT[k] != 0) begin
              nic = nic + 1;
              if (nic == CFG_IT[k]) rel = 1'b1;
            end
          end else begin
            nic = 0;
          end
          if (t_unlock[k]) rel = 1'b1;
          m_locked[k] <= rel ? 0 : 1;
          m_gc[k]     <= rel ? 0 : ngc;
          m_ic[k]     <= rel ? 0 : nic;
        end
      end
    end
  end

  // Every-cycle comparison against the model plus grant invariants.
  always @(negedge clk) begin : compare
    int g;
    logic [N-1:0] exp_g;
    for (int k = 0; k < NI; k++) begin
      g     = model_grant(k);
      exp_g = (g >= 0) ? (N'(1) << g) : '0;
      chk("grants", k, t_grants[k], exp_g);
      chk("locked", k, t_locked[k], (m_locked[k] != 0));
      if (m_locked[k] != 0) chk("lock_id", k, t_id[k], m_id[k]);
      chk("onehot", k, ($countones(t_grants[k]) <= 1), 1);
      chk("grant_subset", k, ((t_grants[k] & ~(t_reqs[k] & {N{t_ready[k]}})) == '0), 1);
    end
  end

  task automatic drive(input int k, input logic [N-1:0] r, input logic rd, input logic ul);
    t_reqs[k]   = r;
    t_ready[k]  = rd;
    t_unlock[k] = ul;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    t_reqs   = '0;
    t_ready  = '0;
    t_unlock = '0;
    step();
    step();
    drive(0, 16'h0030, 1'b1, 1'b0);
    mid();
    for (int k = 0; k < NI; k++) begin
      chk("reset_locked", k, t_locked[k], 0);
      chk("reset_id", k, t_id[k], 0);
    end
    chk("grant_in_reset", 0, t_grants[0], 16'h0010);
    rst = 1'b0;

    // Fixed priority: lowest index wins, then the lock masks others.
    step();
    chk("fix_locked", 0, t_locked[0], 1);
    chk("fix_id", 0, t_id[0], 4);
    drive(0, 16'h0021, 1'b1, 1'b0);
    mid();
    chk("fix_mask", 0, t_grants[0], 16'h0000);
    step();
    drive(0, 16'h0011, 1'b1, 1'b0);
    mid();
    chk("fix_holder", 0, t_grants[0], 16'h0010);
    step();
    drive(0, 16'h0000, 1'b1, 1'b1);
    step();
    drive(0, 16'h0000, 1'b1, 1'b0);
    chk("fix_unlocked", 0, t_locked[0], 0);

    // Round-robin: pointer follows the last grant.
    step();
    drive(1, 16'h0010, 1'b1, 1'b0);
    mid();
    chk("rr_first", 1, t_grants[1], 16'h0010);
    step();
    chk("rr_locked", 1, t_locked[1], 1);
    chk("rr_id4", 1, t_id[1], 4);
    drive(1, 16'h0000, 1'b1, 1'b1);
    step();
    chk("rr_unlocked", 1, t_locked[1], 0);
    drive(1, 16'h0031, 1'b1, 1'b0);
    mid();
    chk("rr_next5", 1, t_grants[1], 16'h0020);
    step();
    chk("rr_id5", 1, t_id[1], 5);
    drive(1, 16'h0020, 1'b1, 1'b1);
    mid();
    chk("rr_grant_with_unlock", 1, t_grants[1], 16'h0020);
    step();
    chk("rr_released", 1, t_locked[1], 0);
    drive(1, 16'h0001, 1'b1, 1'b0);
    mid();
    chk("rr_wrap0", 1, t_grants[1], 16'h0001);
    step();
    drive(1, 16'h0000, 1'b1, 1'b1);
    step();
    drive(1, 16'h0008, 1'b1, 1'b1);
    mid();
    chk("unlock_same_cycle_grant", 1, t_grants[1], 16'h0008);
    step();
    chk("unlock_same_cycle_nolock", 1, t_locked[1], 0);
    drive(1, 16'hFFFF, 1'b0, 1'b0);
    mid();
    chk("not_ready", 1, t_grants[1], 16'h0000);
    step();
    chk("not_ready_nolock", 1, t_locked[1], 0);
    drive(1, 16'h0000, 1'b1, 1'b0);

    // Grant-count release after three grants.
    step();
    drive(2, 16'h0004, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("mg_grant", 2, t_grants[2], 16'h0004);
      step();
      chk("mg_locked", 2, t_locked[2], (i < 2) ? 1 : 0);
    end
    drive(2, 16'h000C, 1'b1, 1'b0);
    mid();
    chk("mg_free_arb", 2, t_grants[2], 16'h0008);
    step();
    drive(2, 16'h0000, 1'b1, 1'b1);
    step();
    drive(2, 16'h0000, 1'b1, 1'b0);

    // Idle-timeout release after four idle cycles.
    drive(3, 16'h0080, 1'b1, 1'b0);
    mid();
    chk("it_first", 3, t_grants[3], 16'h0080);
    step();
    chk("it_id7", 3, t_id[3], 7);
    drive(3, 16'h0100, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("it_masked", 3, t_grants[3], 16'h0000);
      step();
      chk("it_locked", 3, t_locked[3], (i < 3) ? 1 : 0);
    end
    mid();
    chk("it_after", 3, t_grants[3], 16'h0100);
    step();
    drive(3, 16'h0000, 1'b1, 1'b0);

    // Single-grant limit: plain round-robin arbiter, never locks.
    drive(4, 16'h0003, 1'b1, 1'b0);
    mid();
    chk("pl_g0", 4, t_grants[4], 16'h0001);
    step();
    chk("pl_nolock", 4, t_locked[4], 0);
    mid();
    chk("pl_g1", 4, t_grants[4], 16'h0002);
    step();
    mid();
    chk("pl_g0b", 4, t_grants[4], 16'h0001);
    step();
    drive(4, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a lock.
    drive(1, 16'h0200, 1'b1, 1'b0);
    step();
    chk("ar_locked", 1, t_locked[1], 1);
    chk("ar_id9", 1, t_id[1], 9);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_locked_clr", 1, t_locked[1], 0);
    chk("ar_id_clr", 1, t_id[1], 0);
    chk("ar_grant_unlocked_rule", 1, t_grants[1], 16'h0200);
    mid();
    #1;
    rst = 1'b0;
    step();
    chk("ar_relock", 1, t_locked[1], 1);
    drive(1, 16'h0000, 1'b1, 1'b1);
    step();
    drive(1, 16'h0000, 1'b1, 1'b0);

    // Random traffic; the compare process does the checking.
    for (int c = 0; c < 10000; c++) begin
      step();
      for (int k = 0; k < NI; k++) begin
        t_reqs[k]   = N'($urandom & $urandom);
        t_ready[k]  = ($urandom_range(0, 3) != 0);
        t_unlock[k] = ($urandom_range(0, 15) == 0);
      end
    end
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
